// File: rtl/seq_key_responder.sv
// seq_key_responder: watches qualified bus accesses in one page, matches an
// address nibble field against a programmed key sequence, and once the whole
// sequence has been seen answers qualified reads with an LFSR bit stream.
module seq_key_responder #(
    parameter int                      KEY_LEN   = 4,
    parameter int                      NIB_W     = 4,
    parameter logic [KEY_LEN*NIB_W-1:0] KEY      = {4'h9, 4'hA, 4'h8, 4'h2},
    parameter logic [1:0]              PAGE      = 2'b01,
    parameter int                      LFSR_W    = 6,
    parameter logic [LFSR_W-1:0]       LFSR_SEED = 6'b101101,
    parameter logic [LFSR_W-1:0]       LFSR_TAPS = 6'b000011,
    parameter int                      RESP_LEN  = 8,
    parameter bit                      WR_RELOCK = 1'b1,
    localparam int                     IDX_W     = $clog2(KEY_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_stb,
    input  logic             sel_n,
    input  logic [1:0]       ba_page,
    input  logic [NIB_W-1:0] ba_key,
    input  logic             br_w,
    output logic             sdrd_o,
    output logic             sdrd_oe,
    output logic             unlocked,
    output logic [IDX_W-1:0] key_idx
);

    // The response counter keeps at least one bit so RESP_LEN=0 still elaborates.
    localparam int CNT_W = (RESP_LEN < 1) ? 1 : $clog2(RESP_LEN + 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'((RESP_LEN > 0) ? (RESP_LEN - 1) : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(KEY_LEN - 1);

    if (KEY_LEN < 2) begin : g_chk_key_len
        $fatal(1, "seq_key_responder: KEY_LEN must be at least 2");
    end
    if (LFSR_SEED == '0) begin : g_chk_seed
        $fatal(1, "seq_key_responder: LFSR_SEED must be non-zero");
    end
    if (LFSR_TAPS == '0) begin : g_chk_taps
        $fatal(1, "seq_key_responder: LFSR_TAPS must be non-zero");
    end

    typedef enum logic [0:0] {
        ST_LOCKED   = 1'b0,
        ST_UNLOCKED = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [LFSR_W-1:0] lfsr_r, lfsr_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              oe_s;
    logic              qa_s;

    // Select key step i from the packed key without a variable part-select.
    function automatic logic [NIB_W-1:0] key_at(input logic [IDX_W-1:0] i);
        logic [NIB_W-1:0] r;
        r = '0;
        for (int j = 0; j < KEY_LEN; j++) begin
            r = (i == IDX_W'(j)) ? KEY[j*NIB_W +: NIB_W] : r;
        end
        return r;
    endfunction

    assign qa_s = acc_stb & ~sel_n & (ba_page == PAGE);

    // Next-state, key matching and response-read decode.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        lfsr_s  = lfsr_r;
        cnt_s   = cnt_r;
        oe_s    = 1'b0;
        case (state_r)
            ST_LOCKED: begin
                if (qa_s && br_w) begin
                    if (ba_key == key_at(idx_r)) begin
                        if (idx_r == LAST_IDX) begin
                            state_s = ST_UNLOCKED;
                            idx_s   = '0;
                            lfsr_s  = LFSR_SEED;
                            cnt_s   = '0;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        // A wrong nibble may itself be the first key step.
                        idx_s = (ba_key == KEY[NIB_W-1:0]) ? IDX_W'(1) : IDX_W'(0);
                    end
                end else if (qa_s) begin
                    idx_s = '0;
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_UNLOCKED: begin
                if (qa_s && br_w) begin
                    oe_s   = 1'b1;
                    lfsr_s = {^(lfsr_r & LFSR_TAPS), lfsr_r[LFSR_W-1:1]};
                    cnt_s  = cnt_r + CNT_W'(1);
                    if ((RESP_LEN != 0) && (cnt_r == RESP_LAST)) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s = ST_UNLOCKED;
                    end
                end else if (qa_s && WR_RELOCK) begin
                    state_s = ST_LOCKED;
                    idx_s   = '0;
                end else begin
                    state_s = ST_UNLOCKED;
                end
            end
            default: begin
                state_s = ST_LOCKED;
                idx_s   = '0;
            end
        endcase
    end

    // State, match index, LFSR and response counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOCKED;
            idx_r   <= '0;
            lfsr_r  <= LFSR_SEED;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            lfsr_r  <= lfsr_s;
            cnt_r   <= cnt_s;
        end
    end

    // The response bit must appear in the same cycle as the read strobe.
    assign sdrd_oe  = oe_s;
    assign sdrd_o   = oe_s & lfsr_r[0];
    assign unlocked = (state_r == ST_UNLOCKED);
    assign key_idx  = idx_r;

endmodule
